uart_tx_buffer: RTL and testbench

- Synchronous FIFO between the UART controller's TX write path and the UART serializer.
- Accepts bytes from the controller on a valid/ready stream and presents them first-word-fall-through to the transmitter.
- Exports fill level, full/empty and a sticky overflow status for controller status reporting.

---
 rtl/uart_tx_buffer.sv | 93 +++++++++
 tb/tb_uart_tx_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// First-word-fall-through TX byte buffer between the UART controller and the serializer.
// Wrap-bit pointers give full/empty; occupancy and overflow status are registered.
module uart_tx_buffer #(
   parameter int UART_DLEN = 8,
   parameter int DEPTH     = 16,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_flush,
   input  logic                 i_ovf_clr,
   input  logic                 i_s_tvalid,
   output logic                 o_s_tready,
   input  logic [UART_DLEN-1:0] i_s_tdata,
   output logic                 o_m_tvalid,
   input  logic                 i_m_tready,
   output logic [UART_DLEN-1:0] o_m_tdata,
   output logic [AW:0]          o_count,
   output logic                 o_full,
   output logic                 o_empty,
   output logic                 o_overflow
);

   localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
   localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

   logic [UART_DLEN-1:0] mem_r [DEPTH];
   logic [AW:0]          wr_ptr_r;
   logic [AW:0]          rd_ptr_r;
   logic [AW:0]          count_r;
   logic                 overflow_r;
   logic                 full_s;
   logic                 empty_s;
   logic                 push_s;
   logic                 pop_s;

   // Status decode from the registered pointers
   always_comb begin
      empty_s = (wr_ptr_r == rd_ptr_r);
      full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
      push_s  = i_s_tvalid && !full_s;
      pop_s   = !empty_s && i_m_tready;
   end

   assign o_s_tready = ~full_s;
   assign o_m_tvalid = ~empty_s;
   assign o_full     = full_s;
   assign o_empty    = empty_s;
   assign o_m_tdata  = mem_r[rd_ptr_r[AW-1:0]];
   assign o_count    = count_r;
   assign o_overflow = overflow_r;

   // Storage write; a push coinciding with flush is discarded
   always_ff @(posedge clk) begin
      if (push_s && !i_flush) begin
         mem_r[wr_ptr_r[AW-1:0]] <= i_s_tdata;
      end
   end

   // Pointers, occupancy counter and sticky overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         count_r    <= PTR_ZERO;
         overflow_r <= 1'b0;
      end else begin
         if (i_flush) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= PTR_ZERO;
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
               2'b10:   count_r <= count_r + PTR_ONE;
               2'b01:   count_r <= count_r - PTR_ONE;
               default: count_r <= count_r;
            endcase
         end
         // set beats clear when both happen on the same edge
         if (i_s_tvalid && full_s) begin
            overflow_r <= 1'b1;
         end else if (i_ovf_clr) begin
            overflow_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer: a byte queue models the FIFO and is compared each cycle.
module tb_uart_tx_buffer;

   localparam int DLEN  = 8;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   logic            clk = 1'b0;
   logic            rst;
   logic            i_flush, i_ovf_clr, i_s_tvalid, i_m_tready;
   logic [DLEN-1:0] i_s_tdata;
   logic            o_s_tready, o_m_tvalid, o_full, o_empty, o_overflow;
   logic [DLEN-1:0] o_m_tdata;
   logic [AW:0]     o_count;

   int              vectors    = 0;
   int              miscompares = 0;
   bit              mon_en     = 1'b0;
   bit              ovf_m      = 1'b0;
   logic [DLEN-1:0] sb_q [$];

   uart_tx_buffer #(.UART_DLEN(DLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .i_flush(i_flush), .i_ovf_clr(i_ovf_clr),
      .i_s_tvalid(i_s_tvalid), .o_s_tready(o_s_tready), .i_s_tdata(i_s_tdata),
      .o_m_tvalid(o_m_tvalid), .i_m_tready(i_m_tready), .o_m_tdata(o_m_tdata),
      .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Outputs are stable at the falling edge; the model then predicts the next rising edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst) begin
            sb_q.delete();
            ovf_m = 1'b0;
            check("rst_count", 32'(o_count), 32'd0);
            check("rst_mvalid", 32'(o_m_tvalid), 32'd0);
         end else begin
            automatic int  n     = sb_q.size();
            automatic bit  push_m = i_s_tvalid && (n < DEPTH);
            automatic bit  pop_m  = i_m_tready && (n != 0);
            check("count", 32'(o_count), 32'(n));
            check("mvalid", 32'(o_m_tvalid), 32'(n != 0));
            check("stready", 32'(o_s_tready), 32'(n != DEPTH));
            check("overflow", 32'(o_overflow), 32'(ovf_m));
            if (n != 0) check("mdata", 32'(o_m_tdata), 32'(sb_q[0]));
            if (i_s_tvalid && n == DEPTH) ovf_m = 1'b1;
            else if (i_ovf_clr) ovf_m = 1'b0;
            if (i_flush) begin
               sb_q.delete();
            end else begin
               if (pop_m) void'(sb_q.pop_front());
               if (push_m) sb_q.push_back(i_s_tdata);
            end
         end
      end
   end

   initial begin
      #200000;
      check("timeout", 32'd1, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      rst = 1'b1; i_flush = 1'b0; i_ovf_clr = 1'b0; i_s_tvalid = 1'b0;
      i_m_tready = 1'b0; i_s_tdata = 8'h00;
      tick(2);
      rst = 1'b0;
      mon_en = 1'b1;
      tick(1);
      check("idle_empty", 32'(o_empty), 32'd1);
      check("idle_full", 32'(o_full), 32'd0);
      check("idle_count", 32'(o_count), 32'd0);
      check("idle_stready", 32'(o_s_tready), 32'd1);
      check("idle_mvalid", 32'(o_m_tvalid), 32'd0);
      check("idle_ovf", 32'(o_overflow), 32'd0);

      // two pushes, then one pop
      i_s_tvalid = 1'b1; i_s_tdata = 8'hA5;
      tick(1);
      check("fwft_valid", 32'(o_m_tvalid), 32'd1);
      check("fwft_data", 32'(o_m_tdata), 32'hA5);
      i_s_tdata = 8'h3C;
      tick(1);
      i_s_tvalid = 1'b0;
      check("two_count", 32'(o_count), 32'd2);
      check("two_head", 32'(o_m_tdata), 32'hA5);
      i_m_tready = 1'b1;
      tick(1);
      i_m_tready = 1'b0;
      check("pop_data", 32'(o_m_tdata), 32'h3C);
      check("pop_count", 32'(o_count), 32'd1);
      i_m_tready = 1'b1;
      tick(1);
      i_m_tready = 1'b0;
      check("drained", 32'(o_empty), 32'd1);

      // fill to full, attempt overflow, drain in order
      for (int i = 0; i < DEPTH; i++) begin
         i_s_tvalid = 1'b1; i_s_tdata = 8'(i);
         tick(1);
      end
      check("full", 32'(o_full), 32'd1);
      check("full_stready", 32'(o_s_tready), 32'd0);
      i_s_tdata = 8'h10;
      tick(1);
      i_s_tvalid = 1'b0;
      check("ovf_set", 32'(o_overflow), 32'd1);
      check("ovf_count", 32'(o_count), 32'd16);
      i_m_tready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         check("drain_order", 32'(o_m_tdata), 32'(i));
         tick(1);
      end
      i_m_tready = 1'b0;
      check("drain_empty", 32'(o_empty), 32'd1);
      check("ovf_sticky", 32'(o_overflow), 32'd1);
      i_ovf_clr = 1'b1;
      tick(1);
      i_ovf_clr = 1'b0;
      check("ovf_clr", 32'(o_overflow), 32'd0);

      // streaming push+pop across pointer wrap
      i_s_tvalid = 1'b1; i_s_tdata = 8'h64;
      tick(1);
      i_m_tready = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         i_s_tdata = 8'(i * 7);
         tick(1);
         check("stream_count", 32'(o_count), 32'd1);
      end
      i_s_tvalid = 1'b0;
      tick(1);
      i_m_tready = 1'b0;
      check("stream_empty", 32'(o_empty), 32'd1);

      // flush with pending pop
      for (int i = 0; i < 5; i++) begin
         i_s_tvalid = 1'b1; i_s_tdata = 8'(8'hC0 + i);
         tick(1);
      end
      i_s_tvalid = 1'b0;
      i_flush = 1'b1; i_m_tready = 1'b1;
      tick(1);
      i_flush = 1'b0; i_m_tready = 1'b0;
      check("flush_empty", 32'(o_empty), 32'd1);
      check("flush_count", 32'(o_count), 32'd0);
      i_s_tvalid = 1'b1; i_s_tdata = 8'h77;
      tick(1);
      i_s_tvalid = 1'b0;
      check("post_flush", 32'(o_m_tdata), 32'h77);
      i_m_tready = 1'b1;
      tick(1);
      i_m_tready = 1'b0;

      // asynchronous reset mid-cycle with 8 entries stored
      for (int i = 0; i < 8; i++) begin
         i_s_tvalid = 1'b1; i_s_tdata = 8'(8'h50 + i);
         tick(1);
      end
      i_s_tvalid = 1'b0;
      check("pre_rst_count", 32'(o_count), 32'd8);
      #2;
      rst = 1'b1;
      #1;
      check("arst_empty", 32'(o_empty), 32'd1);
      check("arst_full", 32'(o_full), 32'd0);
      check("arst_count", 32'(o_count), 32'd0);
      check("arst_stready", 32'(o_s_tready), 32'd1);
      check("arst_mvalid", 32'(o_m_tvalid), 32'd0);
      check("arst_ovf", 32'(o_overflow), 32'd0);
      tick(1);
      rst = 1'b0;
      tick(1);
      i_s_tvalid = 1'b1; i_s_tdata = 8'h11;
      tick(1);
      i_s_tvalid = 1'b0;
      check("post_rst_data", 32'(o_m_tdata), 32'h11);
      check("post_rst_count", 32'(o_count), 32'd1);
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
